// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, functs, FSM states,
// pc_control and alu_control codes.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_FAULT  = 3'd6
  } state_t;

  localparam logic [3:0] PC_HOLD   = 4'd0;
  localparam logic [3:0] PC_INCR   = 4'd1;
  localparam logic [3:0] PC_BRANCH = 4'd2;
  localparam logic [3:0] PC_JUMP   = 4'd3;
  localparam logic [3:0] PC_JR     = 4'd4;

  localparam logic [3:0] ALU_AND = 4'h0;
  localparam logic [3:0] ALU_OR  = 4'h1;
  localparam logic [3:0] ALU_ADD = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;
  localparam logic [3:0] ALU_SUB = 4'h6;
  localparam logic [3:0] ALU_SLT = 4'h7;
  localparam logic [3:0] ALU_NOR = 4'hC;

  function automatic logic is_known_op(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW};
  endfunction

endpackage

// File: rtl/alu_func_decode.sv
// Combinational R-type funct -> alu_control mapping with an illegal-funct flag.
module alu_func_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       illegal
);

  always_comb begin
    alu_op  = ALU_ADD;
    illegal = 1'b0;
    case (funct)
      FN_ADD, FN_ADDU: alu_op = ALU_ADD;
      FN_SUB, FN_SUBU: alu_op = ALU_SUB;
      FN_AND:          alu_op = ALU_AND;
      FN_OR:           alu_op = ALU_OR;
      FN_XOR:          alu_op = ALU_XOR;
      FN_NOR:          alu_op = ALU_NOR;
      FN_SLT:          alu_op = ALU_SLT;
      FN_JR:           alu_op = ALU_ADD; // jr leaves from DECODE, never reaches EXEC
      default:         illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS sequencer sharing one req/ready memory port between fetch and data access.
// Define MCTRL_ILLEGAL_TRAP_EN to trap unknown opcodes/functs into FAULT instead of retiring them as NOPs.
module multicycle_control_unit
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int ALU_CTRL_W  = 4,
  parameter int PC_CTRL_W   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           instruction,
  input  logic                  alu_zero,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  mem_wren,
  output logic                  mem_sel,
  output logic                  ir_wren,
  output logic [PC_CTRL_W-1:0]  pc_control,
  output logic                  reg_file_wren,
  output logic                  reg_file_rmux_select,
  output logic                  reg_file_dmux_select,
  output logic                  alu_mux_select,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  retire,
  output logic                  fault
);

  localparam int CW = $clog2(MEM_TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(MEM_TIMEOUT - 1);

  state_t        state, next;
  logic [CW-1:0] wait_cnt;
  logic [5:0]    opcode, funct;
  logic [3:0]    func_alu, pc_op, alu_op;
  logic          func_illegal, is_rtype, is_jr, is_sw, illegal, timeout;
  logic          unused_ir;

  assign opcode    = instruction[31:26];
  assign funct     = instruction[5:0];
  assign unused_ir = ^instruction[25:6];
  assign is_rtype  = (opcode == OP_RTYPE);
  assign is_jr     = is_rtype && (funct == FN_JR);
  assign is_sw     = (opcode == OP_SW);
  assign illegal   = !is_known_op(opcode) || (is_rtype && func_illegal);
  assign timeout   = (wait_cnt == CNT_MAX);

  alu_func_decode u_func (
    .funct   (funct),
    .alu_op  (func_alu),
    .illegal (func_illegal)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_RESET;
    else      state <= next;
  end

  // Counts stalled request cycles; any state change (completion, timeout, entry) clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      wait_cnt <= '0;
    else if ((state == ST_FETCH || state == ST_MEM) && next == state)
      wait_cnt <= wait_cnt + 1'b1;
    else
      wait_cnt <= '0;
  end

  always_comb begin
    next                 = state;
    mem_req              = 1'b0;
    mem_wren             = 1'b0;
    mem_sel              = 1'b0;
    ir_wren              = 1'b0;
    pc_op                = PC_HOLD;
    reg_file_wren        = 1'b0;
    reg_file_rmux_select = 1'b0;
    reg_file_dmux_select = 1'b0;
    alu_mux_select       = 1'b0;
    alu_op               = ALU_AND;
    retire               = 1'b0;
    fault                = 1'b0;
    case (state)
      ST_RESET: next = ST_FETCH;
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_wren = 1'b1;
          pc_op   = PC_INCR;
          next    = ST_DECODE;
        end else if (timeout) begin
          next = ST_FAULT;
        end
      end
      ST_DECODE: begin
        if (opcode == OP_J || is_jr) begin
          pc_op  = is_jr ? PC_JR : PC_JUMP;
          retire = 1'b1;
          next   = ST_FETCH;
        end else if (illegal) begin
`ifdef MCTRL_ILLEGAL_TRAP_EN
          next = ST_FAULT;
`else
          retire = 1'b1;
          next   = ST_FETCH;
`endif
        end else begin
          next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (is_rtype) begin
          alu_op = func_alu;
          next   = ST_WB;
        end else if (opcode == OP_BEQ) begin
          alu_op = ALU_SUB;
          pc_op  = alu_zero ? PC_BRANCH : PC_HOLD;
          retire = 1'b1;
          next   = ST_FETCH;
        end else begin
          // only addi, lw and sw get past DECODE here
          alu_mux_select = 1'b1;
          alu_op         = ALU_ADD;
          next           = (opcode == OP_ADDI) ? ST_WB : ST_MEM;
        end
      end
      ST_MEM: begin
        mem_req  = 1'b1;
        mem_sel  = 1'b1;
        mem_wren = is_sw;
        if (mem_ready) begin
          retire = is_sw;
          next   = is_sw ? ST_FETCH : ST_WB;
        end else if (timeout) begin
          next = ST_FAULT;
        end
      end
      ST_WB: begin
        reg_file_wren        = 1'b1;
        reg_file_rmux_select = is_rtype;
        reg_file_dmux_select = (opcode == OP_LW);
        retire               = 1'b1;
        next                 = ST_FETCH;
      end
      ST_FAULT: fault = 1'b1;
      default:  next = ST_RESET;
    endcase
  end

  assign pc_control  = PC_CTRL_W'(pc_op);
  assign alu_control = ALU_CTRL_W'(alu_op);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized check of multicycle_control_unit against a per-instruction cycle-trace model.
module tb_multicycle_control_unit;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instruction = '0;
  logic        alu_zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_wren, mem_sel, ir_wren;
  logic [3:0]  pc_control, alu_control;
  logic        reg_file_wren, reg_file_rmux_select, reg_file_dmux_select, alu_mux_select;
  logic        retire, fault;

  multicycle_control_unit #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .alu_zero(alu_zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_wren(mem_wren), .mem_sel(mem_sel), .ir_wren(ir_wren),
    .pc_control(pc_control), .reg_file_wren(reg_file_wren),
    .reg_file_rmux_select(reg_file_rmux_select), .reg_file_dmux_select(reg_file_dmux_select),
    .alu_mux_select(alu_mux_select), .alu_control(alu_control), .retire(retire), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       req, wren, sel, ir;
    logic [3:0] pc;
    logic       rw, rmux, dmux, amux;
    logic [3:0] alu;
    logic       ret, flt;
  } outs_t;

  outs_t exp_q[$];
  logic  rdy_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic outs_t observed();
    return {mem_req, mem_wren, mem_sel, ir_wren, pc_control, reg_file_wren, reg_file_rmux_select,
            reg_file_dmux_select, alu_mux_select, alu_control, retire, fault};
  endfunction

  // ALU code per R-type funct, -1 when the funct is not an ALU operation
  function automatic int alu_ref(input logic [5:0] fn);
    case (fn)
      6'h20, 6'h21: return 2;
      6'h22, 6'h23: return 6;
      6'h24:        return 0;
      6'h25:        return 1;
      6'h26:        return 3;
      6'h27:        return 12;
      6'h2A:        return 7;
      default:      return -1;
    endcase
  endfunction

  function automatic logic rnd();
    return logic'($urandom_range(0, 1));
  endfunction

  function automatic void push(input logic r, input outs_t o);
    rdy_q.push_back(r);
    exp_q.push_back(o);
  endfunction

  function automatic bit fault_tail();
    outs_t f = '0;
    f.flt = 1'b1;
    for (int i = 0; i < 3; i++) push(rnd(), f);
    return 1'b1;
  endfunction

  // w stalled cycles then completion; stalling TMO cycles means timeout
  function automatic bit mem_phase(input int w, input outs_t stall, input outs_t done);
    for (int i = 0; i < w && i < TMO; i++) push(1'b0, stall);
    if (w >= TMO) return 1'b0;
    push(1'b1, done);
    return 1'b1;
  endfunction

  // Builds the expected per-cycle output trace of one instruction; returns 1 if it ends in FAULT.
  function automatic bit build(input logic [31:0] ins, input logic az, input int wf, input int wm);
    logic [5:0] op = ins[31:26];
    logic [5:0] fn = ins[5:0];
    int    a     = alu_ref(fn);
    bit    rtype = (op == 6'h00);
    bit    jr    = rtype && (fn == 6'h08);
    bit    bad   = rtype ? (a < 0 && !jr) : !(op inside {6'h02, 6'h04, 6'h08, 6'h23, 6'h2B});
    outs_t b = '0;
    outs_t d;
    b.req = 1'b1;
    d = b; d.ir = 1'b1; d.pc = 4'd1;
    if (!mem_phase(wf, b, d)) return fault_tail();
    d = '0;
    if (op == 6'h02 || jr) begin
      d.pc = jr ? 4'd4 : 4'd3; d.ret = 1'b1; push(rnd(), d); return 1'b0;
    end
    if (bad) begin
`ifdef MCTRL_ILLEGAL_TRAP_EN
      push(rnd(), d); return fault_tail();
`else
      d.ret = 1'b1; push(rnd(), d); return 1'b0;
`endif
    end
    push(rnd(), d);
    if (op == 6'h04) begin
      d.alu = 4'd6; d.pc = az ? 4'd2 : 4'd0; d.ret = 1'b1; push(rnd(), d); return 1'b0;
    end
    d.amux = !rtype;
    d.alu  = rtype ? a[3:0] : 4'd2;
    push(rnd(), d);
    if (op == 6'h23 || op == 6'h2B) begin
      b = '0; b.req = 1'b1; b.sel = 1'b1; b.wren = (op == 6'h2B);
      d = b; d.ret = (op == 6'h2B);
      if (!mem_phase(wm, b, d)) return fault_tail();
      if (op == 6'h2B) return 1'b0;
    end
    d = '0; d.rw = 1'b1; d.ret = 1'b1; d.rmux = rtype; d.dmux = (op == 6'h23);
    push(rnd(), d);
    return 1'b0;
  endfunction

  function automatic int lat_ref(input logic [31:0] ins, input int wf, input int wm);
    logic [5:0] op = ins[31:26];
    if (op == 6'h02 || (op == 6'h00 && ins[5:0] == 6'h08)) return 2 + wf;
    if (op == 6'h00) return (alu_ref(ins[5:0]) < 0 ? 2 : 4) + wf;
    case (op)
      6'h04:   return 3 + wf;
      6'h08:   return 4 + wf;
      6'h23:   return 5 + wf + wm;
      6'h2B:   return 4 + wf + wm;
      default: return 2 + wf;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk); rst = 1'b0; mem_ready = 1'b1;
    #1 chk("rst_low", 32'(observed()), 32'h0);
    @(negedge clk); rst = 1'b1;
    #1 chk("rst_release", 32'(observed()), 32'h0);
  endtask

  task automatic run(input string nm, input logic [31:0] ins, input logic az, input int wf,
                     input int wm, input int abort_at);
    bit flt;
    int got_lat = 0;
    exp_q.delete(); rdy_q.delete();
    flt = build(ins, az, wf, wm);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      instruction = ins; alu_zero = az; mem_ready = rdy_q[i];
      #1 chk($sformatf("%s %h c%0d", nm, ins, i), 32'(observed()), 32'(exp_q[i]));
      if (retire && got_lat == 0) got_lat = i + 1;
      if (i == abort_at) begin
        #2 rst = 1'b0;
        #1 chk($sformatf("%s async_drop", nm), 32'(observed()), 32'h0);
        @(negedge clk); rst = 1'b1;
        #1 chk($sformatf("%s after_rst", nm), 32'(observed()), 32'h0);
        return;
      end
    end
    if (flt) do_reset();
    else chk($sformatf("%s %h latency", nm, ins), 32'(got_lat), 32'(lat_ref(ins, wf, wm)));
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r = $urandom();
    logic [5:0]  fl [9] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A};
    case ($urandom_range(0, 9))
      0, 1: begin r[31:26] = 6'h00; r[5:0] = fl[$urandom_range(0, 8)]; end
      2:    r[31:26] = 6'h00;
      3:    r[31:26] = 6'h02;
      4:    begin r[31:26] = 6'h00; r[5:0] = 6'h08; end
      5:    r[31:26] = 6'h04;
      6:    r[31:26] = 6'h08;
      7:    r[31:26] = 6'h23;
      8:    r[31:26] = 6'h2B;
      default: ;
    endcase
    return r;
  endfunction

  function automatic int rand_wait();
    return ($urandom_range(0, 9) == 0) ? TMO : int'($urandom_range(0, TMO - 1));
  endfunction

  initial begin
    #1 chk("reset_state", 32'(observed()), 32'h0);
    do_reset();
    run("add",      32'h00221820, 1'b0, 0, 0, -1);
    run("lw_wait3", 32'h8C220004, 1'b0, 0, 3, -1);
    run("beq_z1",   32'h10220003, 1'b1, 0, 0, -1);
    run("beq_z0",   32'h10220003, 1'b0, 0, 0, -1);
    run("fetch_to", 32'h00221820, 1'b0, TMO, 0, -1);
    run("sw_abort", 32'hAC220008, 1'b0, 0, 2, 3);
    run("illegal",  32'hFC000000, 1'b0, 0, 0, -1);
    run("sw_edge",  32'hAC220008, 1'b0, TMO - 1, TMO - 1, -1);
    run("lw_to",    32'h8C220004, 1'b0, 1, TMO, -1);
    for (int k = 0; k < 200; k++)
      run("rand", rand_instr(), rnd(), rand_wait(), rand_wait(), -1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
